// File: rtl/obi_i2c_master_if.sv
// OBI request/response bundle for the I2C master. The slave side is the
// peripheral; the master side is the SoC interconnect (or a testbench).
interface obi_i2c_master_if;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;

  modport slave (
    input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o
  );

  modport master (
    output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o
  );
endinterface

// File: rtl/obi_i2c_master.sv
// OBI-mapped single-byte I2C master: START, addr+R/W, one data byte, STOP.
// Register port and bit engine run independently; pad outputs are open-drain enables.
module obi_i2c_master #(
  parameter int CLK_FREQ         = 50_000_000,
  parameter int I2C_FREQ         = 400_000,
  parameter int DEFAULT_PRESCALE = CLK_FREQ / I2C_FREQ - 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  obi_i2c_master_if.slave   obi,
  output logic              scl_oe_o,
  output logic              sda_oe_o,
  input  logic              sda_i
);

  localparam logic [15:0] PRESC_RST = 16'(DEFAULT_PRESCALE);

  localparam logic [1:0] B_IDLE = 2'd0;
  localparam logic [1:0] B_GNT  = 2'd1;
  localparam logic [1:0] B_RESP = 2'd2;
  localparam logic [1:0] B_WAIT = 2'd3;

  localparam logic [2:0] E_IDLE  = 3'd0;
  localparam logic [2:0] E_START = 3'd1;
  localparam logic [2:0] E_ADDR  = 3'd2;
  localparam logic [2:0] E_AACK  = 3'd3;
  localparam logic [2:0] E_DATA  = 3'd4;
  localparam logic [2:0] E_DACK  = 3'd5;
  localparam logic [2:0] E_STOP  = 3'd6;

  logic [1:0]  bst_q, bst_d;
  logic        gnt_q, rvalid_q;
  logic [31:0] rdata_q, rd_mux;
  logic [15:0] presc_q, presc_d;

  logic [2:0]  est_q, est_d;
  logic [1:0]  ph_q, ph_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sda_s1_q, sda_s2_q;

  logic [1:0]  sel;
  logic        wr_en, cmd_wr, tick, scl_low;
  logic        unused_ok;

  assign sel       = obi.obi_addr_i[3:2];
  assign wr_en     = (bst_q == B_GNT) && obi.obi_we_i;
  assign cmd_wr    = wr_en && (sel == 2'd1) && !busy_q;
  assign unused_ok = ^{obi.obi_be_i, obi.obi_addr_i[31:4], obi.obi_addr_i[1:0],
                       obi.obi_wdata_i[31:16]};

  // ---------------- bus side ----------------
  // B_RESP never samples req; B_WAIT does, so a held request is re-granted
  // three cycles after the previous grant.
  always_comb begin
    bst_d = bst_q;
    case (bst_q)
      B_IDLE:  if (obi.obi_req_i) bst_d = B_GNT;
      B_GNT:   bst_d = B_RESP;
      B_RESP:  bst_d = B_WAIT;
      default: bst_d = obi.obi_req_i ? B_GNT : B_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0:    rd_mux = {16'b0, presc_q};
      2'd2:    rd_mux = {29'b0, done_q, nack_q, busy_q};
      2'd3:    rd_mux = {24'b0, rx_q};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (wr_en && sel == 2'd0) presc_d = obi.obi_wdata_i[15:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bst_q    <= B_IDLE;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      presc_q  <= PRESC_RST;
    end else begin
      bst_q    <= bst_d;
      gnt_q    <= (bst_d == B_GNT);
      rvalid_q <= (bst_d == B_RESP);
      rdata_q  <= (bst_q == B_GNT && !obi.obi_we_i) ? rd_mux : '0;
      presc_q  <= presc_d;
    end
  end

  assign obi.obi_gnt_o    = gnt_q;
  assign obi.obi_rvalid_o = rvalid_q;
  assign obi.obi_rdata_o  = rdata_q;

  // ---------------- bit engine ----------------
  // >= so a PRESCALE shrunk mid-quarter still wraps on the next cycle.
  assign tick = busy_q && (cnt_q >= presc_q);

  always_comb begin
    est_d  = est_q;
    ph_d   = ph_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    wdat_d = wdat_q;
    rw_d   = rw_q;
    busy_d = busy_q;
    nack_d = nack_q;
    done_d = done_q;
    cnt_d  = (!busy_q || tick) ? 16'd0 : cnt_q + 16'd1;
    if (cmd_wr) begin
      // CMD[7:0] is already the {addr7,rw} byte sent on the wire
      tx_d   = obi.obi_wdata_i[7:0];
      rw_d   = obi.obi_wdata_i[0];
      wdat_d = obi.obi_wdata_i[15:8];
      busy_d = 1'b1;
      done_d = 1'b0;
      nack_d = 1'b0;
      est_d  = E_START;
      ph_d   = 2'd0;
      bit_d  = 3'd0;
    end else if (tick) begin
      ph_d = ph_q + 2'd1;
      if (ph_q == 2'd2) begin
        if (est_q == E_AACK) nack_d = sda_s2_q;
        if (est_q == E_DACK && !rw_q) nack_d = sda_s2_q;
        if (est_q == E_DATA && rw_q) rx_d = {rx_q[6:0], sda_s2_q};
      end
      if (ph_q == 2'd3) begin
        case (est_q)
          E_START: est_d = E_ADDR;
          E_ADDR, E_DATA: begin
            tx_d  = {tx_q[6:0], 1'b1};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) est_d = (est_q == E_ADDR) ? E_AACK : E_DACK;
          end
          E_AACK: begin
            if (nack_q) est_d = E_STOP;
            else begin
              est_d = E_DATA;
              tx_d  = rw_q ? 8'hFF : wdat_q;
            end
          end
          E_DACK: est_d = E_STOP;
          E_STOP: begin
            est_d  = E_IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
          default: est_d = E_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      est_q    <= E_IDLE;
      ph_q     <= 2'd0;
      bit_q    <= 3'd0;
      tx_q     <= '0;
      rx_q     <= '0;
      wdat_q   <= '0;
      rw_q     <= 1'b0;
      busy_q   <= 1'b0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      sda_s1_q <= 1'b0;
      sda_s2_q <= 1'b0;
    end else begin
      est_q    <= est_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      wdat_q   <= wdat_d;
      rw_q     <= rw_d;
      busy_q   <= busy_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
    end
  end

  // Pad enables decode straight from state flops so reset releases them at once.
  assign scl_low = (ph_q == 2'd0) || (ph_q == 2'd3);

  always_comb begin
    scl_oe_o = 1'b0;
    sda_oe_o = 1'b0;
    case (est_q)
      E_START: begin
        scl_oe_o = (ph_q == 2'd3);
        sda_oe_o = ph_q[1];
      end
      E_ADDR, E_DATA: begin
        scl_oe_o = scl_low;
        sda_oe_o = ~tx_q[7];
      end
      E_AACK, E_DACK: scl_oe_o = scl_low;
      E_STOP: begin
        scl_oe_o = (ph_q == 2'd0);
        sda_oe_o = (ph_q != 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_obi_i2c_master.sv
// Directed bench for obi_i2c_master with a bit-level I2C slave model
// (fixed address 0x50) watching the open-drain enables.
module tb_obi_i2c_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_oe, sda_oe, sda_i;
  obi_i2c_master_if bus();

  obi_i2c_master dut (
    .clk_i(clk), .rst_i(rst), .obi(bus),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // ---- slave model ----
  logic       pull = 1'b0;
  logic       present = 1'b1;
  logic [7:0] rdbyte = 8'h00;
  logic [7:0] abyte = 8'h00, dbyte = 8'h00;
  logic       acked = 1'b0, stop_seen = 1'b0, dack_oe = 1'b1;
  logic       prev_scl = 1'b1, prev_sdam = 1'b1, prev_line = 1'b1;
  int         rises = 0, starts = 0, busy_cnt = 0;

  assign sda_i = ~(sda_oe | pull);

  always @(negedge clk) begin
    logic scl, sdam, line;
    int   nxt;
    scl  = ~scl_oe;
    sdam = ~sda_oe;
    line = ~(sda_oe | pull);
    if (scl && prev_scl && prev_sdam && !sdam) begin
      starts++;
      rises = 0;
      pull  = 1'b0;
      acked = 1'b0;
    end else if (scl && prev_scl && !prev_line && line) begin
      stop_seen = 1'b1;
    end
    if (scl && !prev_scl) begin
      rises++;
      if (rises <= 8) abyte = {abyte[6:0], line};
      else if (rises >= 10 && rises <= 17) dbyte = {dbyte[6:0], line};
      if (rises == 18) dack_oe = sda_oe;
    end
    if (!scl && prev_scl) begin
      nxt = rises + 1;
      if (nxt == 9) begin
        acked = present && (abyte[7:1] == 7'h50);
        pull  = acked;
      end else if (nxt >= 10 && nxt <= 17)
        pull = (abyte[0] && acked) ? ~rdbyte[17-nxt] : 1'b0;
      else if (nxt == 18)
        pull = !abyte[0] && acked;
      else
        pull = 1'b0;
    end
    prev_scl  = scl;
    prev_sdam = sdam;
    prev_line = ~(sda_oe | pull);
  end

  always @(negedge clk) if (dut.busy_q) busy_cnt++;

  // ---- bus helpers ----
  task automatic obi_xfer(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd);
    bit ok = 0;
    @(negedge clk);
    bus.obi_req_i   = 1'b1;
    bus.obi_we_i    = we;
    bus.obi_addr_i  = addr;
    bus.obi_wdata_i = wd;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.obi_gnt_o) begin ok = 1; break; end
    end
    if (!ok) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    bus.obi_req_i = 1'b0;
    chk("rvalid", {31'b0, bus.obi_rvalid_o}, 1);
    rd = bus.obi_rdata_o;
  endtask

  task automatic wait_done(output logic [31:0] st);
    bit ok = 0;
    st = '0;
    for (int n = 0; n < 300; n++) begin
      obi_xfer(1'b0, 32'hE000_0008, 0, st);
      if (!st[0]) begin ok = 1; break; end
    end
    if (!ok) chk("busy_timeout", 0, 1);
  endtask

  task automatic arm();
    stop_seen = 1'b0;
    starts    = 0;
    busy_cnt  = 0;
    rises     = 0;
    dack_oe   = 1'b1;
  endtask

  logic [31:0] rd;

  initial begin
    bus.obi_req_i   = 1'b0;
    bus.obi_we_i    = 1'b0;
    bus.obi_addr_i  = '0;
    bus.obi_be_i    = 4'hF;
    bus.obi_wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {31'b0, bus.obi_gnt_o}, 0);
    chk("rst_rvalid", {31'b0, bus.obi_rvalid_o}, 0);
    chk("rst_pads", {30'b0, scl_oe, sda_oe}, 0);
    rst = 1'b0;

    // OBI timing with req held across two transfers
    @(negedge clk);
    bus.obi_req_i  = 1'b1;
    bus.obi_addr_i = 32'hE000_0008;
    @(negedge clk);
    chk("t1_gnt", {31'b0, bus.obi_gnt_o}, 1);
    chk("t1_rvalid", {31'b0, bus.obi_rvalid_o}, 0);
    @(negedge clk);
    chk("t2_gnt", {31'b0, bus.obi_gnt_o}, 0);
    chk("t2_rvalid", {31'b0, bus.obi_rvalid_o}, 1);
    chk("t2_rdata", bus.obi_rdata_o, 0);
    @(negedge clk);
    chk("t3_gnt", {31'b0, bus.obi_gnt_o}, 0);
    @(negedge clk);
    chk("t4_gnt", {31'b0, bus.obi_gnt_o}, 1);
    bus.obi_req_i = 1'b0;
    @(negedge clk);
    chk("t5_rvalid", {31'b0, bus.obi_rvalid_o}, 1);
    repeat (3) @(negedge clk);

    obi_xfer(1'b0, 32'hE000_0000, 0, rd);
    chk("presc_rst", rd, 124);
    obi_xfer(1'b0, 32'hE000_0008, 0, rd);
    chk("status_rst", rd, 0);

    // write transaction
    obi_xfer(1'b1, 32'hE000_0000, 3, rd);
    obi_xfer(1'b0, 32'hE000_0000, 0, rd);
    chk("presc_wr", rd, 3);
    present = 1'b1;
    arm();
    obi_xfer(1'b1, 32'hE000_0004, 32'h0000_A5A0, rd);
    wait_done(rd);
    chk("wr_status", rd, 32'h4);
    chk("wr_abyte", {24'b0, abyte}, 32'hA0);
    chk("wr_dbyte", {24'b0, dbyte}, 32'hA5);
    chk("wr_busy_clk", busy_cnt, 320);
    chk("wr_rises", rises, 19);
    chk("wr_stop", {31'b0, stop_seen}, 1);
    chk("wr_starts", starts, 1);

    // read transaction
    rdbyte = 8'h3C;
    arm();
    obi_xfer(1'b1, 32'hE000_0004, 32'h0000_00A1, rd);
    wait_done(rd);
    chk("rd_status", rd, 32'h4);
    chk("rd_abyte", {24'b0, abyte}, 32'hA1);
    chk("rd_dack_oe", {31'b0, dack_oe}, 0);
    obi_xfer(1'b0, 32'hE000_000C, 0, rd);
    chk("rd_rxdata", rd, 32'h3C);
    obi_xfer(1'b0, 32'hE000_0004, 0, rd);
    chk("cmd_reads0", rd, 0);

    // address NACK
    present = 1'b0;
    arm();
    obi_xfer(1'b1, 32'hE000_0004, 32'h0000_A5A0, rd);
    wait_done(rd);
    chk("nk_status", rd, 32'h6);
    chk("nk_busy_clk", busy_cnt, 176);
    chk("nk_rises", rises, 10);
    chk("nk_stop", {31'b0, stop_seen}, 1);

    // CMD while busy is acknowledged but ignored
    present = 1'b1;
    arm();
    obi_xfer(1'b1, 32'hE000_0004, 32'h0000_A5A0, rd);
    obi_xfer(1'b1, 32'hE000_0004, 32'h0000_1234, rd);
    chk("bz_wr_rdata", rd, 0);
    wait_done(rd);
    chk("bz_status", rd, 32'h4);
    chk("bz_abyte", {24'b0, abyte}, 32'hA0);
    chk("bz_dbyte", {24'b0, dbyte}, 32'hA5);
    chk("bz_starts", starts, 1);
    chk("bz_busy_clk", busy_cnt, 320);

    // reset in the middle of the address byte
    arm();
    obi_xfer(1'b1, 32'hE000_0004, 32'h0000_A5A0, rd);
    begin
      bit ok = 0;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (rises >= 3 && scl_oe) begin ok = 1; break; end
      end
      chk("mid_addr_reached", {31'b0, ok}, 1);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_pads", {30'b0, scl_oe, sda_oe}, 0);
    @(negedge clk);
    rst = 1'b0;
    obi_xfer(1'b0, 32'hE000_0008, 0, rd);
    chk("rst_mid_status", rd, 0);
    obi_xfer(1'b0, 32'hE000_0000, 0, rd);
    chk("rst_mid_presc", rd, 124);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "timeout");
  end
endmodule
